// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes,
// FSM states, default bus timeout and the alignment rule.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEFAULT_MAX_WAIT = 15;

  // Size 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane steering: replicates store data and builds byte enables, or selects
// and sign/zero-extends the addressed lane of load data.
module lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter bit IS_LOAD = 1'b0
) (
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [3:0]  be
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  store_be;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_b     = din[7:0];
    lane_h     = addr_lo[1] ? din[31:16] : din[15:0];
    load_data  = din;
    store_data = din;
    store_be   = 4'b1111;

    case (addr_lo)
      2'd1:    lane_b = din[15:8];
      2'd2:    lane_b = din[23:16];
      2'd3:    lane_b = din[31:24];
      default: lane_b = din[7:0];
    endcase

    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~zero_ext & lane_b[7]}}, lane_b};
        store_data = {4{din[7:0]}};
        store_be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        load_data  = {{16{~zero_ext & lane_h[15]}}, lane_h};
        store_data = {2{din[15:0]}};
        store_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_data  = din;
        store_data = din;
        store_be   = 4'b1111;
      end
    endcase

    dout = IS_LOAD ? load_data : store_data;
    be   = IS_LOAD ? 4'b0000 : store_be;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one outstanding bus access at a time,
// stalls the pipeline while busy, aborts after MAX_WAIT unacknowledged cycles.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        null_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] rd_out_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          uns_q;

  logic          misaligned;
  logic          req_seen;
  logic          start;
  logic          busy;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic [31:0]   ld_data;
  logic [3:0]    ld_be;

  // Store path works on the live request; load path on the latched access.
  lsu_align #(.IS_LOAD(1'b0)) u_store_align (
    .size     (mem_size_i),
    .zero_ext (mem_unsigned_i),
    .addr_lo  (addr_i[1:0]),
    .din      (wdata_i),
    .dout     (st_data),
    .be       (st_be)
  );

  lsu_align #(.IS_LOAD(1'b1)) u_load_align (
    .size     (size_q),
    .zero_ext (uns_q),
    .addr_lo  (addr_q[1:0]),
    .din      (bus_rdata_i),
    .dout     (ld_data),
    .be       (ld_be)
  );

  assign misaligned = is_misaligned(mem_size_i, addr_i[1:0]);
  assign req_seen   = mem_req_i & ~null_i & (state == IDLE);
  assign start      = req_seen & ~misaligned;
  assign busy       = (state == BUSY);

  assign stall_o     = rst_n_i & (start | busy);
  assign bus_req_o   = busy;
  assign bus_we_o    = busy & we_q;
  assign bus_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wdata_o = busy ? wdata_q : 32'h0;
  assign bus_be_o    = busy ? be_q : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      size_q     <= SZ_BYTE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      rd_out_o   <= '0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_seen && misaligned) begin
            misalign_o <= 1'b1;
            rd_out_o   <= '0;
          end else if (start) begin
            addr_q   <= addr_i;
            size_q   <= mem_size_i;
            we_q     <= mem_we_i;
            uns_q    <= mem_unsigned_i;
            wdata_q  <= mem_we_i ? st_data : 32'h0;
            be_q     <= mem_we_i ? st_be : ld_be;
            wait_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the final allowed cycle still counts as a normal completion.
          if (bus_ack_i) begin
            rd_out_o <= we_q ? 32'h0 : ld_data;
            state    <= DONE;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            timeout_o <= 1'b1;
            rd_out_o  <= '0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: stimulus queues expected bus requests and
// completions; an independent monitor checks them as the DUT presents them.
module tb_dmem_lsu;

  localparam int MAX_WAIT = 15;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        mis;
    logic [31:0] rd;
    logic        tmo;
    int          stall_len;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        mem_req_i, mem_we_i, mem_unsigned_i, null_i;
  logic [1:0]  mem_size_i;
  logic [31:0] addr_i, wdata_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [31:0] rd_out_o;
  logic        stall_o, misalign_o, timeout_o;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  dmem_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .null_i         (null_i),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_be_o       (bus_be_o),
    .bus_ack_i      (bus_ack_i),
    .bus_rdata_i    (bus_rdata_i),
    .rd_out_o       (rd_out_o),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: request contents while bus_req_o is high, completion on its fall,
  // exception pulses whenever they appear.
  initial begin
    logic  prev_req = 1'b0;
    int    stall_run = 0;
    req_t  cur;
    resp_t r;
    cur = '{addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (!rst_n_i) begin
        prev_req  = 1'b0;
        stall_run = 0;
      end else begin
        if (bus_req_o && !prev_req) begin
          if (req_q.size() == 0) check("req_q_size", req_q.size(), 1);
          else cur = req_q.pop_front();
        end
        if (bus_req_o) begin
          check("bus_addr",  bus_addr_o,  cur.addr);
          check("bus_we",    bus_we_o,    cur.we);
          check("bus_be",    bus_be_o,    cur.be);
          check("bus_wdata", bus_wdata_o, cur.wdata);
        end
        if (!bus_req_o && prev_req) begin
          if (resp_q.size() == 0) check("resp_q_size", resp_q.size(), 1);
          else begin
            r = resp_q.pop_front();
            check("done_kind",   misalign_o, r.mis);
            check("rd_out",      rd_out_o,   r.rd);
            check("timeout",     timeout_o,  r.tmo);
            check("done_stall",  stall_o,    1'b0);
            check("stall_cycles", stall_run, r.stall_len);
          end
        end else if (timeout_o) begin
          check("spurious_timeout", timeout_o, 1'b0);
        end
        if (misalign_o) begin
          if (resp_q.size() == 0) check("resp_q_size", resp_q.size(), 1);
          else begin
            r = resp_q.pop_front();
            check("mis_kind",  1'b1,       r.mis);
            check("mis_rd",    rd_out_o,   r.rd);
            check("mis_stall", stall_o,    1'b0);
          end
        end
        if (stall_o) stall_run++;
        else stall_run = 0;
        prev_req = bus_req_o;
      end
    end
  end

  // ack_at: BUSY cycle index (0 = first) carrying the ack; negative = never.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ack_at, input bit hold,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd);
    int i;
    req_q.push_back('{addr: {addr[31:2], 2'b00}, we: we, be: exp_be, wdata: exp_wd});
    resp_q.push_back('{mis: 1'b0, rd: exp_rd, tmo: (ack_at < 0),
                       stall_len: (ack_at < 0) ? MAX_WAIT + 1 : ack_at + 2});
    @(posedge clk); #1;
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_unsigned_i = uns;
    addr_i = addr; wdata_i = wdata;
    #1 check("req_stall", stall_o, 1'b1);
    @(posedge clk); #1;
    if (!hold) mem_req_i = 1'b0;
    i = 0;
    while (1) begin
      if (i == ack_at) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdata;
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      if (i == ack_at || i == MAX_WAIT - 1) break;
      i++;
    end
    // Now in DONE: a stray ack here must not disturb anything.
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    mem_req_i = 1'b0;
    check("idle_bus_req", bus_req_o, 1'b0);
    check("idle_rd_hold", rd_out_o, exp_rd);
    @(posedge clk); #1;
    check("no_reissue", bus_req_o, 1'b0);
  endtask

  task automatic do_mis(input logic [1:0] sz, input logic [31:0] addr);
    resp_q.push_back('{mis: 1'b1, rd: 32'h0, tmo: 1'b0, stall_len: 0});
    @(posedge clk); #1;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = sz; mem_unsigned_i = 1'b0; addr_i = addr;
    #1 check("mis_req_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    check("mis_pulse", misalign_o, 1'b1);
    @(posedge clk); #1;
    check("mis_one_cycle", misalign_o, 1'b0);
    check("mis_no_bus", bus_req_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n_i = 1'b0; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10;
    mem_unsigned_i = 1'b0; addr_i = 32'h100; wdata_i = 32'h0; null_i = 1'b0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    @(posedge clk); #1;
    check("rst_stall",     stall_o,     1'b0);
    check("rst_bus_req",   bus_req_o,   1'b0);
    check("rst_bus_we",    bus_we_o,    1'b0);
    check("rst_bus_addr",  bus_addr_o,  32'h0);
    check("rst_bus_wdata", bus_wdata_o, 32'h0);
    check("rst_bus_be",    bus_be_o,    4'h0);
    check("rst_rd_out",    rd_out_o,    32'h0);
    check("rst_misalign",  misalign_o,  1'b0);
    check("rst_timeout",   timeout_o,   1'b0);
    mem_req_i = 1'b0;
    @(posedge clk); #1;
    rst_n_i = 1'b1;

    //    we    sz     uns   addr          wdata         rdata         ack hold be       wdata_exp     rd_exp
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'h8765_4321, 0, 1'b0, 4'b0000, 32'h0,        32'h8765_4321);
    do_op(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80);
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_0080);
    do_op(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
    do_op(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_op(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'hDEAD_BE5A, 32'h0,        2, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    do_op(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_1234, 0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001);
    do_op(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        32'h8001_F234, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_F234);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,        32'h1234_7FFF, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_7FFF);
    do_op(1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0,        32'h1357_9BDF, 0, 1'b0, 4'b0000, 32'h0,        32'h1357_9BDF);

    do_mis(2'b10, 32'h0000_0101);
    do_mis(2'b01, 32'h0000_0103);
    do_mis(2'b11, 32'h0000_0102);

    // Bubble: request flagged null must be invisible.
    @(posedge clk); #1;
    mem_req_i = 1'b1; null_i = 1'b1; mem_size_i = 2'b10; addr_i = 32'h0000_0101;
    #1 check("null_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    mem_req_i = 1'b0; null_i = 1'b0;
    check("null_bus_req", bus_req_o, 1'b0);
    check("null_misalign", misalign_o, 1'b0);

    // Timeout, then an ack landing on the last allowed cycle.
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, -1,           1'b0, 4'b0000, 32'h0, 32'h0);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0, 32'h2468_ACE0, MAX_WAIT - 1, 1'b0, 4'b0000, 32'h0, 32'h2468_ACE0);

    // Reset in the middle of a BUSY phase.
    req_q.push_back('{addr: 32'h0000_0400, we: 1'b0, be: 4'b0000, wdata: 32'h0});
    @(posedge clk); #1;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_unsigned_i = 1'b0; addr_i = 32'h0000_0400;
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n_i = 1'b0;
    #1 check("rst_mid_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_bus_req", bus_req_o, 1'b0);
    check("rst_mid_rd_out", rd_out_o, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_1234;
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    check("post_rst_bus_req", bus_req_o, 1'b0);
    check("post_rst_rd_out", rd_out_o, 32'h0);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
